// File: rtl/set_pkg.sv
// Shared definitions for the set-condition compare sequencer: opcodes,
// FSM state encoding and the opcode-to-set-bit decode.
package set_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_SLT = 3'd0;
  localparam logic [2:0] OP_SEQ = 3'd1;
  localparam logic [2:0] OP_SNE = 3'd2;
  localparam logic [2:0] OP_SGT = 3'd3;
  localparam logic [2:0] OP_SLE = 3'd4;
  localparam logic [2:0] OP_SGE = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_SGE);
  endfunction

  // lt is the signed less-than (N^V); z is the zero flag of a-b.
  function automatic logic set_bit(input logic [2:0] op, input logic lt, input logic z);
    case (op)
      OP_SLT:  return lt;
      OP_SEQ:  return z;
      OP_SNE:  return !z;
      OP_SGT:  return !lt && !z;
      OP_SLE:  return lt || z;
      OP_SGE:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of a - b, computed as a + ~b + cin.
module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/set_cmp_seq.sv
// Multi-cycle set-condition sequencer: subtracts a-b CHUNK bits per cycle,
// accumulates N/Z/C/V and returns a zero-extended 0/1 set result.
module set_cmp_seq
  import set_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff, diff_nxt;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic             carry, zacc, zacc_nxt;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             accept, last_chunk;
  logic             flag_n, flag_v, lt;

  // Gated with rst_n so the block never advertises readiness while held in reset.
  assign req_ready  = rst_n && (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign accept     = req_valid && (state == IDLE);
  assign last_chunk = (idx == LAST_IDX);

  sub_chunk #(.CHUNK(CHUNK)) u_sub (
    .a    (a_q[idx*CHUNK +: CHUNK]),
    .b    (b_q[idx*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    diff_nxt = diff;
    diff_nxt[idx*CHUNK +: CHUNK] = slice_sum;
    zacc_nxt = zacc && (slice_sum == '0);
    flag_n   = diff_nxt[WIDTH-1];
    flag_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
    lt       = flag_n ^ flag_v;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = op_legal(req_op) ? RUN : RESP;
      RUN:     if (last_chunk) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      diff       <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      zacc       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= req_a;
          b_q   <= req_b;
          op_q  <= req_op;
          idx   <= '0;
          carry <= 1'b1;
          zacc  <= 1'b1;
          if (!op_legal(req_op)) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end
        end
        RUN: begin
          diff  <= diff_nxt;
          carry <= slice_cout;
          zacc  <= zacc_nxt;
          idx   <= idx + 1'b1;
          // Final slice: flags come straight from the combinational next values.
          if (last_chunk) begin
            rsp_result <= {{(WIDTH-1){1'b0}}, set_bit(op_q, lt, zacc_nxt)};
            rsp_flags  <= {flag_n, zacc_nxt, slice_cout, flag_v};
            rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_cmp_seq.sv
// Directed self-checking bench for set_cmp_seq at default parameters.
module tb_set_cmp_seq;
  import set_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  set_cmp_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_op = OP_SEQ;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 16);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] res, input logic [3:0] flags,
                           input logic err);
    check({tag, "_result"}, rsp_result, res);
    check({tag, "_flags"}, 32'(rsp_flags), 32'(flags));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] op, input logic [31:0] res, input logic [3:0] flags,
                     input logic err, input int lat);
    accept(a, b, op);
    wait_rsp(tag, lat);
    check_rsp(tag, res, flags, err);
    finish_rsp(tag);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_rsp("rst", 32'd0, 4'b0000, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Flags are {N,Z,C,V}.
    run("seq_zero",  32'd0, 32'd0, OP_SEQ, 32'd1, 4'b0110, 1'b0, 4);
    run("slt_1_m1",  32'd1, 32'hFFFF_FFFF, OP_SLT, 32'd0, 4'b0000, 1'b0, 4);
    run("sgt_1_m1",  32'd1, 32'hFFFF_FFFF, OP_SGT, 32'd1, 4'b0000, 1'b0, 4);
    run("slt_min_1", 32'h8000_0000, 32'd1, OP_SLT, 32'd1, 4'b0011, 1'b0, 4);
    run("sge_min_1", 32'h8000_0000, 32'd1, OP_SGE, 32'd0, 4'b0011, 1'b0, 4);
    run("slt_5_5",   32'd5, 32'd5, OP_SLT, 32'd0, 4'b0110, 1'b0, 4);
    run("seq_5_5",   32'd5, 32'd5, OP_SEQ, 32'd1, 4'b0110, 1'b0, 4);
    run("sne_5_5",   32'd5, 32'd5, OP_SNE, 32'd0, 4'b0110, 1'b0, 4);
    run("sgt_5_5",   32'd5, 32'd5, OP_SGT, 32'd0, 4'b0110, 1'b0, 4);
    run("sle_5_5",   32'd5, 32'd5, OP_SLE, 32'd1, 4'b0110, 1'b0, 4);
    run("sge_5_5",   32'd5, 32'd5, OP_SGE, 32'd1, 4'b0110, 1'b0, 4);
    // Borrow across a chunk boundary, and a nonzero low chunk only.
    run("seq_borrow", 32'h0000_0100, 32'h0000_00FF, OP_SEQ, 32'd0, 4'b0010, 1'b0, 4);
    run("seq_low_nz", 32'h0000_0001, 32'd0, OP_SEQ, 32'd0, 4'b0010, 1'b0, 4);
    run("sgt_7_3",    32'd7, 32'd3, OP_SGT, 32'd1, 4'b0010, 1'b0, 4);

    // Backpressure: hold the response while a stray request pulses.
    accept(32'h8000_0000, 32'd1, OP_SLT);
    wait_rsp("bp", 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_a = 32'd0; req_b = 32'd0; req_op = OP_SEQ;
      @(posedge clk); #1;
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
      check_rsp("bp_hold", 32'd1, 4'b0011, 1'b0);
    end
    req_valid = 1'b0;
    finish_rsp("bp");
    @(posedge clk); #1;
    check("bp_no_stray_accept", 32'(req_ready), 32'd1);

    run("illegal_6", 32'd9, 32'd9, 3'd6, 32'd0, 4'b0000, 1'b1, 1);
    run("illegal_7", 32'd1, 32'd2, 3'd7, 32'd0, 4'b0000, 1'b1, 1);
    // Leave a result of 1 registered so the reset clear below is observable.
    run("sle_pre_rst", 32'd2, 32'd3, OP_SLE, 32'd1, 4'b1000, 1'b0, 4);

    // Reset while processing idx=2.
    accept(32'd3, 32'd7, OP_SLT);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrun_result", rsp_result, 32'd0);
    check("midrun_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrun_no_resp", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrun_ready_after", 32'(req_ready), 32'd1);
    run("slt_3_7", 32'd3, 32'd7, OP_SLT, 32'd1, 4'b1000, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_cmp_seq.md
Name: set_cmp_seq

Overview:
- Multi-cycle compare sequencer for the set-condition logic (slt/seq/sne/sgt/sle/sge).
- Accepts two operands and a set opcode over a valid/ready handshake.
- Computes a-b serially, CHUNK bits per cycle, through a narrow subtractor slice, accumulating N/Z/C/V.
- Returns a zero-extended 0/1 set result over a second valid/ready handshake. Sits between instruction issue and the register write-back mux.

Parameters:
- WIDTH, 32, operand and result width.
- CHUNK, 8, bits subtracted per cycle. WIDTH % CHUNK must be 0; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  3  0=SLT 1=SEQ 2=SNE 3=SGT 4=SLE 5=SGE; 6,7 illegal.
- req_a  in  WIDTH  operand a, signed.
- req_b  in  WIDTH  operand b, signed.
- rsp_valid  out  1  result present; high only in RESP.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  WIDTH  {WIDTH-1 zeros, set bit}.
- rsp_flags  out  4  {N,Z,C,V} of a-b.
- rsp_err  out  1  illegal opcode.

Behaviour:
- Reset (async, rst_n low): state=IDLE; rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0; internal regs cleared. req_ready=0 while rst_n low, 1 after release.
- States:
  - IDLE: req_valid&&req_ready on an edge latches a, b, op; sets idx=0, carry=1, zacc=1. Goes to RUN for legal op; RESP for illegal op.
  - RUN: each edge computes slice = a[idx] + ~b[idx] + carry (CHUNK bits) and writes it into diff[idx]. Then carry=cout, zacc &= (slice==0), idx++. On the edge processing idx=NCHUNK-1, go to RESP with outputs registered.
  - RESP: outputs held stable until rsp_valid&&rsp_ready; that edge returns to IDLE.
- Flags:
  - N = diff[WIDTH-1]
  - Z = zacc
  - C = final carry (1 means a>=b unsigned)
  - V = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB])
  - lt = N^V
- Set bit:
  - SLT = lt
  - SEQ = Z
  - SNE = !Z
  - SGT = !lt && !Z
  - SLE = lt || Z
  - SGE = !lt
- Illegal op: RESP one edge after acceptance; rsp_result=0, rsp_flags=0, rsp_err=1.
- Latency: rsp_valid rises NCHUNK cycles after the accepting edge for legal ops (4 at defaults); 1 cycle for illegal ops.
- Throughput: no overlap. req_ready stays low through RUN and RESP and returns the cycle after the response handshake, giving at least one idle cycle between requests.
- req_* is sampled only at the accept edge; later changes are ignored.
- req_valid during RUN/RESP is not accepted and causes no side effects.
- Reset mid-RUN or mid-RESP aborts immediately; no partial result is ever presented.
- rsp_result, rsp_flags and rsp_err hold their last values in IDLE, but are valid only while rsp_valid is high.

Decomposition:
- Shared package set_pkg holds:
  - opcode localparams OP_SLT..OP_SGE;
  - state encoding IDLE/RUN/RESP;
  - default WIDTH.
- Sub-module sub_chunk (CHUNK-bit a + ~b + cin -> sum, cout) is purely combinational and instantiated once.
- FSM, operand/diff registers and flag/set decode stay in set_cmp_seq.

Test Plan:
- a=0, b=0, op=SEQ -> rsp_valid after 4 cycles; result=1; flags N0 Z1 C1 V0; err=0.
- a=1, b=0xFFFFFFFF, op=SLT -> result=0; op=SGT -> result=1; C=0, N=0, V=0.
- a=0x80000000, b=1, op=SLT -> result=1 (diff=0x7FFFFFFF, N=0, V=1); op=SGE -> 0.
- a=5, b=5 over all six ops -> SLT0 SEQ1 SNE0 SGT0 SLE1 SGE1, each on the first rsp_valid cycle.
- Backpressure and protocol:
  - rsp_ready low for 3 cycles -> result/flags stable, req_ready=0, and a req_valid pulse mid-RESP is not accepted.
  - op=6 -> rsp_valid 1 cycle after accept with err=1, result=0.
- Reset: drop rst_n during RUN idx=2 -> rsp_valid=0 and result=0 immediately. After release, req_ready=1, and a=3, b=7, SLT -> result=1.
